// File: rtl/v2_filter_ctrl.sv
// v2_filter_ctrl
//   Sequencer and event capture for the v2 trapezoidal filter channel.
//   Runs the filter, masks its output while the pipeline settles, arms a
//   threshold trigger, finds the peak amplitude/time of each pulse, hands the
//   result downstream over valid/ready and enforces a dead time before re-arm.
//
// Ports
//   clk, reset         system clock (posedge), asynchronous active-high reset
//   enable             1 = acquire, 0 = stop and clear the filter
//   threshold          unsigned trigger level
//   filt_data          unsigned filter output
//   filt_run           1 = filter runs, 0 = filter pipeline held cleared
//   busy               1 in any state other than IDLE
//   ev_valid/ev_ready  event handshake
//   ev_amp, ev_time    peak amplitude and timestamp of the peak sample
//   ev_pileup          peak search hit MAX_PEAK
//   ev_count, ev_lost  accepted events / crossings missed in HOLD or DEAD
//                      (both saturating, cleared only by reset)
//
// Defaults assume V2_WIDTH=16, V2_k=16, V2_l=16.
module v2_filter_ctrl #(
  parameter int WIDTH    = 16,
  parameter int SETTLE   = 36,
  parameter int MAX_PEAK = 32,
  parameter int DEAD     = 16,
  parameter int TS_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [WIDTH-1:0]    threshold,
  input  logic [WIDTH-1:0]    filt_data,
  output logic                filt_run,
  output logic                busy,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [WIDTH-1:0]    ev_amp,
  output logic [TS_WIDTH-1:0] ev_time,
  output logic                ev_pileup,
  output logic [15:0]         ev_count,
  output logic [15:0]         ev_lost
);

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_ARMED, S_PEAK, S_HOLD, S_DEAD
  } state_t;

  state_t              state;
  logic [15:0]         cnt;       // settle / peak width / dead-time counter
  logic [WIDTH-1:0]    max_r;
  logic [TS_WIDTH-1:0] tmax;
  logic [TS_WIDTH-1:0] ts;
  logic                prev_above;

  logic above;
  logic lost_edge;
  logic peak_up;

  assign above     = filt_data > threshold;
  assign peak_up   = filt_data > max_r;
  assign lost_edge = above && !prev_above && (state == S_HOLD || state == S_DEAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      max_r      <= '0;
      tmax       <= '0;
      ts         <= '0;
      prev_above <= 1'b0;
      filt_run   <= 1'b0;
      busy       <= 1'b0;
      ev_valid   <= 1'b0;
      ev_amp     <= '0;
      ev_time    <= '0;
      ev_pileup  <= 1'b0;
      ev_count   <= '0;
      ev_lost    <= '0;
    end else begin
      ts         <= ts + 1'b1;
      prev_above <= above;
      if (lost_edge && ev_lost != '1)
        ev_lost <= ev_lost + 1'b1;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_WARMUP;
            cnt      <= '0;
            filt_run <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_WARMUP: begin
          if (!enable) begin
            state    <= S_IDLE;
            filt_run <= 1'b0;
            busy     <= 1'b0;
          end else if (cnt == 16'(SETTLE - 1)) begin
            state <= S_ARMED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_ARMED: begin
          if (!enable) begin
            state    <= S_IDLE;
            filt_run <= 1'b0;
            busy     <= 1'b0;
          end else if (above) begin
            max_r <= filt_data;
            tmax  <= ts;
            cnt   <= 16'd1;
            state <= S_PEAK;
          end
        end

        S_PEAK: begin
          if (!enable) begin
            state    <= S_IDLE;
            filt_run <= 1'b0;
            busy     <= 1'b0;
          end else if (filt_data < max_r) begin
            state     <= S_HOLD;
            ev_amp    <= max_r;
            ev_time   <= tmax;
            ev_pileup <= 1'b0;
            ev_valid  <= 1'b1;
          end else begin
            if (peak_up) begin
              max_r <= filt_data;
              tmax  <= ts;
            end
            // Pile-up latches the maximum including this cycle's sample.
            if (cnt + 16'd1 >= 16'(MAX_PEAK)) begin
              state     <= S_HOLD;
              ev_amp    <= peak_up ? filt_data : max_r;
              ev_time   <= peak_up ? ts : tmax;
              ev_pileup <= 1'b1;
              ev_valid  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            if (ev_count != '1)
              ev_count <= ev_count + 1'b1;
            cnt   <= '0;
            state <= S_DEAD;
          end
        end

        S_DEAD: begin
          if (cnt == 16'(DEAD - 1)) begin
            if (enable) begin
              state <= S_ARMED;
            end else begin
              state    <= S_IDLE;
              filt_run <= 1'b0;
              busy     <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          filt_run <= 1'b0;
          busy     <= 1'b0;
          ev_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
